// File: rtl/fifo.sv
// Single-clock FIFO with full/empty flags and registered overflow/underflow pulses.
// Pointers carry one extra wrap bit to tell full from empty.
module fifo #(
  parameter int WIDTH     = 8,
  parameter int FIFO_SIZE = 16,
  parameter int PTR_WIDTH = $clog2(FIFO_SIZE)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [FIFO_SIZE];

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [PTR_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic                 do_wr;
  logic                 do_rd;

  assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) &&
                 (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

  // Acceptance decisions use pre-edge flags only.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    ovf_d    = wr_en & full;
    unf_d    = rd_en & empty;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_addr] <= wdata;
  end

  assign rdata     = rdata_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: expected words queued on accepted writes,
// popped and compared on accepted reads.
module tb_fifo;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       empty, full, overflow, underflow;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] sb [$];
  logic [7:0] exp_rdata;
  logic       exp_ovf, exp_unf;
  logic [7:0] last_word;

  fifo #(.WIDTH(8), .FIFO_SIZE(16)) dut (
    .clk(clk), .res(res),
    .wr_en(wr_en), .rd_en(rd_en),
    .wdata(wdata), .rdata(rdata),
    .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic r,
                      input logic [7:0] d);
    wr_en = w; rd_en = r; wdata = d;
    exp_ovf = w && (sb.size() == 16);
    exp_unf = r && (sb.size() == 0);
    if (r && sb.size() > 0) exp_rdata = sb.pop_front();
    if (w && !exp_ovf) begin
      sb.push_back(d);
      last_word = d;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    sb.delete();
    exp_rdata = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags empty=%b full=%b want 1 0", empty, full);
    end
    compared++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_err ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    compared++;
    if (rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_rdata got %h want 00", rdata);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (full !== 1'b0) begin
        mismatched++;
        $display("FAIL fill_early_full i=%0d got %b want 0", i, full);
      end
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      compared++;
      if (overflow !== 1'b0) begin
        mismatched++;
        $display("FAIL fill_ovf i=%0d got %b want 0", i, overflow);
      end
    end
    compared++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      mismatched++;
      $display("FAIL fill_flags full=%b empty=%b want 1 0", full, empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill16();
    step(1'b1, 1'b0, 8'hEE);
    compared++;
    if (overflow !== exp_ovf || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_pulse got %b want 1", overflow);
    end
    step(1'b1, 1'b0, 8'hEF);
    compared++;
    if (overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_sustain got %b want 1", overflow);
    end
    step(1'b0, 1'b0, 8'h00);
    compared++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_clear ovf=%b full=%b want 0 1", overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      compared++;
      if (rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL ovf_data i=%0d got %h want %h", i, rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    fill16();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      compared++;
      if (rdata !== exp_rdata || underflow !== 1'b0) begin
        mismatched++;
        $display("FAIL drain i=%0d rdata=%h unf=%b want %h 0",
                 i, rdata, underflow, exp_rdata);
      end
      compared++;
      if (empty !== (i == 15)) begin
        mismatched++;
        $display("FAIL drain_empty i=%0d got %b want %b", i, empty, i == 15);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] w16;
    do_reset();
    fill16();
    w16 = last_word;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    compared++;
    if (underflow !== 1'b1 || exp_unf !== 1'b1) begin
      mismatched++;
      $display("FAIL unf_pulse got %b want 1", underflow);
    end
    compared++;
    if (rdata !== w16) begin
      mismatched++;
      $display("FAIL unf_hold got %h want %h", rdata, w16);
    end
    step(1'b0, 1'b0, 8'h00);
    compared++;
    if (underflow !== 1'b0 || rdata !== w16) begin
      mismatched++;
      $display("FAIL unf_clear unf=%b rdata=%h want 0 %h",
               underflow, rdata, w16);
    end
  endtask

  task automatic test_wrap_simul();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      compared++;
      if (rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL wrap_rd10 i=%0d got %h want %h", i, rdata, exp_rdata);
      end
    end
    fill16();
    compared++;
    if (full !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_full got %b want 1", full);
    end
    step(1'b1, 1'b1, 8'h99);
    compared++;
    if (rdata !== exp_rdata || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL simul_full rdata=%h ovf=%b want %h 1",
               rdata, overflow, exp_rdata);
    end
    compared++;
    if (full !== 1'b0 || empty !== 1'b0 || sb.size() != 15) begin
      mismatched++;
      $display("FAIL simul_occ full=%b empty=%b want 0 0", full, empty);
    end
    step(1'b1, 1'b1, 8'h5A);
    compared++;
    if (rdata !== exp_rdata || overflow !== 1'b0 || full !== 1'b0) begin
      mismatched++;
      $display("FAIL simul_mid rdata=%h ovf=%b full=%b want %h 0 0",
               rdata, overflow, full, exp_rdata);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00);
      compared++;
      if (rdata !== exp_rdata) begin
        mismatched++;
        $display("FAIL wrap_drain i=%0d got %h want %h", i, rdata, exp_rdata);
      end
    end
    compared++;
    if (empty !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_empty got %b want 1", empty);
    end
    step(1'b1, 1'b1, 8'hC3);
    compared++;
    if (underflow !== 1'b1 || empty !== 1'b0) begin
      mismatched++;
      $display("FAIL simul_empty unf=%b empty=%b want 1 0", underflow, empty);
    end
    step(1'b0, 1'b1, 8'h00);
    compared++;
    if (rdata !== 8'hC3 || rdata !== exp_rdata) begin
      mismatched++;
      $display("FAIL simul_empty_data got %h want c3", rdata);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b1, 8'h00);
    #2 res = 1'b1;
    #1;
    compared++;
    if (empty !== 1'b1 || rdata !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset empty=%b rdata=%h want 1 00", empty, rdata);
    end
    sb.delete();
    exp_rdata = '0;
    @(posedge clk); #1 res = 1'b0;
    step(1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    compared++;
    if (rdata !== 8'hA5 || rdata !== exp_rdata) begin
      mismatched++;
      $display("FAIL post_reset_data got %h want a5", rdata);
    end
    step(1'b0, 1'b1, 8'h00);
    compared++;
    if (rdata !== exp_rdata || empty !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_2nd rdata=%h empty=%b want %h 1",
               rdata, empty, exp_rdata);
    end
  endtask

  initial begin
    last_word = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap_simul();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
